// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // One result/quotient bit per CALC cycle
    localparam int unsigned NUM_STEPS = 32;
    localparam logic [5:0]  CNT_LAST  = 6'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Operand magnitude extraction, special-case detection and final
// sign correction / result selection for muldiv_unit.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    // Start-side view: live decode inputs
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   rs1,
    input  logic [WIDTH-1:0]   rs2,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               neg,
    output logic               special,
    output logic [WIDTH-1:0]   special_val,
    // Finish-side view: latched op state and raw iteration result
    input  logic [2:0]         fin_op,
    input  logic               fin_neg,
    input  logic               fin_special,
    input  logic [WIDTH-1:0]   fin_special_val,
    input  logic [2*WIDTH-1:0] fin_acc,
    input  logic [WIDTH-1:0]   fin_rem,
    output logic [WIDTH-1:0]   fin_result
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic a_signed, b_signed, neg_a, neg_b, div0, ovf;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Signedness per op, magnitudes, result sign and spec-defined special results
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        neg_a = a_signed & rs1[WIDTH-1];
        neg_b = b_signed & rs2[WIDTH-1];
        mag_a = neg_a ? -rs1 : rs1;
        mag_b = neg_b ? -rs2 : rs2;
        // Remainder follows the dividend; everything else follows the sign product
        neg   = is_rem(op) ? neg_a : (neg_a ^ neg_b);

        div0    = is_div(op) && (rs2 == '0);
        ovf     = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MIN_NEG) && (rs2 == '1);
        special = div0 | ovf;
        if (div0) begin
            special_val = is_rem(op) ? rs1 : '1;
        end else begin
            special_val = is_rem(op) ? '0 : MIN_NEG;
        end
    end

    // Negate and pick the requested half / quotient / remainder
    always_comb begin
        // Quotient sits in the low half of the accumulator, so one negation covers both
        prod_fix = fin_neg ? -fin_acc : fin_acc;
        rem_fix  = fin_neg ? -fin_rem : fin_rem;
        case (fin_op)
            OP_MUL, OP_DIV, OP_DIVU:       fin_result = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_result = prod_fix[2*WIDTH-1:WIDTH];
            default:                       fin_result = rem_fix;
        endcase
        if (fin_special) begin
            fin_result = fin_special_val;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle over 32 CALC cycles.
// Optional MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow
// complete straight from the start edge without entering CALC.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e             state_q, state_d;
    logic [5:0]         cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_q, spec_q;
    logic [WIDTH-1:0]   spec_val_q, result_q;

    logic               load, finish, qbit;
    logic [WIDTH:0]     sum, trial;
    logic [WIDTH-1:0]   mag_a, mag_b, special_val, fin_result;
    logic               neg, special;

    muldiv_signfix #(
        .WIDTH(WIDTH)
    ) u_signfix (
        .op              (op),
        .rs1             (rs1),
        .rs2             (rs2),
        .mag_a           (mag_a),
        .mag_b           (mag_b),
        .neg             (neg),
        .special         (special),
        .special_val     (special_val),
        .fin_op          (op_q),
        .fin_neg         (neg_q),
        .fin_special     (spec_q),
        .fin_special_val (spec_val_q),
        .fin_acc         (acc_d),
        .fin_rem         (rem_d),
        .fin_result      (fin_result)
    );

    // One multiply or divide step on the latched operands
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        sum   = '0;
        trial = '0;
        qbit  = 1'b0;
        if (is_div(op_q)) begin
            // 33-bit partial remainder: shift in the next dividend bit, trial-subtract
            trial = {rem_q, acc_q[WIDTH-1]};
            if (trial >= {1'b0, opnd_q}) begin
                sum   = trial - {1'b0, opnd_q};
                rem_d = sum[WIDTH-1:0];
                qbit  = 1'b1;
            end else begin
                rem_d = trial[WIDTH-1:0];
            end
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
        end else begin
            sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end
    end

    // Next-state decode; start only honoured when not busy
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    load = 1'b1;
`ifdef MULDIV_FAST_SPECIAL_EN
                    state_d = special ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand latches, iteration registers and result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MUL;
            opnd_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt_q      <= '0;
                op_q       <= op;
                // Multiply: mag_a is the addend, mag_b shifts out of the low half.
                // Divide: mag_b is the divisor, mag_a shifts out as quotient shifts in.
                opnd_q     <= is_div(op) ? mag_b : mag_a;
                acc_q      <= {{WIDTH{1'b0}}, (is_div(op) ? mag_a : mag_b)};
                rem_q      <= '0;
                neg_q      <= neg;
                spec_q     <= special;
                spec_val_q <= special_val;
`ifdef MULDIV_FAST_SPECIAL_EN
                if (special) begin
                    result_q <= special_val;
                end
`endif
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 6'd1;
                acc_q <= acc_d;
                rem_q <= rem_d;
                if (finish) begin
                    result_q <= fin_result;
                end
            end
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    muldiv_unit #(
        .WIDTH(32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics with wide integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0]        ua, ub, pu;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            OP_MUL:    begin p = sa * sb; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            OP_MULHU:  begin pu = ua * ub; return pu[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                pu = ua / ub;
                return pu[31:0];
            end
            OP_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                pu = ua % ub;
                return pu[31:0];
            end
        endcase
    endfunction

    function automatic bit spec_case(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        return (o[2] && b == 0) ||
               ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request; returns #1 after the sampling edge with inputs scrambled
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 3'($urandom);
        rs1   = $urandom;
        rs2   = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        bit fs;
        fs = FAST && spec_case(o, a, b);
        launch(o, a, b);
        check({tag, " busy"}, 32'(busy), fs ? 32'd0 : 32'd1);
        wait_done(n);
        check({tag, " latency"}, 32'(n), fs ? 32'd0 : 32'd32);
        check({tag, " result"}, result, exp);
        @(posedge clk); #1;
        check({tag, " done pulse"}, {30'b0, busy, done}, 32'd0);
        check({tag, " held"}, result, exp);
    endtask

    initial begin
        int n, cnt;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);

        // rst beats start on the same edge
        start = 1'b1; op = OP_MUL; rs1 = 32'd5; rs2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        check("rst wins busy", 32'(busy), 32'd0);

        run_op("mul 7x6", OP_MUL, 32'd7, 32'd6, 32'h0000_002A);
        run_op("mulh min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2);
        run_op("divu /0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_op("remu /0", OP_REMU, 32'd100, 32'd0, 32'd100);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op("div neg/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_op("rem neg/0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

        // start while busy must be ignored
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignore busy", 32'(busy), 32'd1);
        wait_done(n);
        check("ignore latency", 32'(n), 32'd27);
        check("ignore result", result, 32'd14);
        @(posedge clk); #1;

        // reset in the middle of CALC
        launch(OP_MUL, 32'd7, 32'd6);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("midrst no done", 32'(cnt), 32'd0);

        // back-to-back: restart in the DONE cycle
        launch(OP_MUL, 32'd2, 32'd3);
        wait_done(n);
        check("b2b first latency", 32'(n), 32'd32);
        check("b2b first result", result, 32'd6);
        start = 1'b1; op = OP_MUL; rs1 = 32'd4; rs2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b no bubble", {30'b0, busy, done}, 32'd2);
        wait_done(n);
        check("b2b second latency", 32'(n), 32'd32);
        check("b2b second result", result, 32'd20);
        @(posedge clk); #1;

        // randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the RISC-V core. It takes rs1/rs2 and funct3 from decode, computes over multiple cycles, and presents a 32-bit result. That result feeds the `in1` leg of the writeback 2:1 result mux, whose `ctrl` selects between ALU result (`in0`) and M-extension result (`in1`). The core stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width; only 32 is supported.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when `busy`=0.
- `op` input 3: funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1` input 32: multiplicand or dividend.
- `rs2` input 32: multiplier or divisor.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse; `result` is valid in that cycle.
- `result` output 32: last completed result, held until the next completion.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: `busy`=1; a 6-bit step counter runs 0..31.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE or DONE with `start`=1: latch `op`, `rs1`, `rs2`, clear the counter, go to CALC.
  - DONE with `start`=0: go to IDLE.
  - CALC: increment the counter each cycle; at count 31, write `result` and go to DONE.
- Signed handling:
  - Take magnitudes of the signed operands; signedness per op (MULHSU: rs1 signed, rs2 unsigned).
  - Iterate unsigned, then negate the result if the operand signs differ.
  - REM result takes the dividend's sign.
- Multiply: radix-2 shift-add into a 64-bit accumulator. MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide: restoring, one quotient bit per cycle, with a 33-bit partial remainder. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero:
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return `rs1`.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - DIV returns 0x80000000.
  - REM returns 0.
- `start` while `busy`=1 is ignored; the operands of the operation in flight are unaffected.
- `rs1`/`rs2`/`op` may change after the start edge; the latched copies are used.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0x00000000, counter 0.
- Normal latency, start sampled at edge E0:
  - `busy`=1 after E0 through E32.
  - `done`=1 and `result` valid after E32 (32 CALC cycles).
  - Returns to IDLE at E33 unless restarted.
- Back-to-back: `start` sampled during DONE gives `done` for one cycle, then `busy` rises with no idle bubble.
- Reset mid-CALC: the next edge forces IDLE with all outputs at reset values; the in-flight operation is discarded and `done` never pulses.
- `rst` and `start` on the same edge: `rst` wins.
- `result` changes only on the edge entering DONE.

## Configuration
- `MULDIV_FAST_SPECIAL_EN` defined:
  - Divide by zero and signed overflow are detected at the start edge.
  - FSM goes IDLE→DONE directly and `result` is written at that same edge.
  - `done` appears 1 cycle after start; `busy` never rises.
- `MULDIV_FAST_SPECIAL_EN` undefined:
  - These cases take the full 32-cycle CALC path.
  - Final correction logic forces the same spec-defined result values.
- Normal operations are unaffected either way.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings as localparams: OP_MUL through OP_REMU.
  - the state enum: IDLE, CALC, DONE.
  - the iteration count constant, 32.
- One combinational sub-module, `muldiv_signfix`, is natural. It does operand magnitude extraction and final result negation/selection, and is instantiated once.

## Test plan
- MUL, rs1=7, rs2=6, start at E0 → `busy` high E0..E32; `done` pulse after E32 with `result`=0x0000002A.
- Upper-half products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU 100/7 → 14; REMU → 2.
- DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. `done` after 1 cycle with the macro, after 33 cycles without.
- Busy and reset:
  - Second `start` (MUL 3×3) at E5 during DIVU 100/7 is ignored; result is 14.
  - `rst` at E10 of a fresh operation → next cycle `busy`=0, `done`=0, `result`=0, with no later `done`.
- Back-to-back: MUL 2×3 with MUL 4×5 started in its DONE cycle → `done` pulses 33 cycles apart, `result` 6 then 20.
